fetch_pc_gen: RTL and testbench

- Front-end PC generator, directly upstream of branch_predictor and the instruction cache.
- Each cycle it drives a 3-wide fetch group (fetch_EN/fetch_pc) to the predictor and I-cache.
- It consumes predict_direction/predict_pc and the per-slot cache hit bits, then presents the valid prefix of the group to the fetch buffer.
- It computes the next PC from: branch-FU squash redirect, downstream stall, predicted-taken target, or sequential advance.

---
 rtl/fetch_pc_gen.sv | 109 ++++++++++
 tb/tb_fetch_pc_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Front-end PC generator: drives a FW-wide fetch group to the predictor/I-cache,
// delivers the live prefix to the fetch buffer and selects the next PC.
module fetch_pc_gen #(
    parameter int               XLEN     = 32,
    parameter int               FW       = 3,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [XLEN-1:0]            squash_pc,
    input  logic                       stall,
    input  logic [FW-1:0]              icache_hit,
    input  logic [FW-1:0]              predict_direction,
    input  logic [FW-1:0][XLEN-1:0]    predict_pc,
    output logic [FW-1:0]              fetch_EN,
    output logic [FW-1:0][XLEN-1:0]    fetch_pc,
    output logic [FW-1:0]              out_valid,
    output logic [FW-1:0]              out_pred_taken,
    output logic [FW-1:0][XLEN-1:0]    out_pred_pc,
    output logic [1:0]                 state_out
);

    localparam logic [1:0]      ST_RUN      = 2'd0;
    localparam logic [1:0]      ST_REDIRECT = 2'd1;
    localparam logic [XLEN-1:0] INSN_BYTES  = XLEN'(3'd4);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [FW-1:0]   live_s;
    logic            run_s;

    // State and PC registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            pc_r    <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Slot addresses and live prefix: a miss, or a taken slot after its own slot, ends the group
    always_comb begin
        logic chain_v;
        chain_v  = 1'b1;
        live_s   = {FW{1'b0}};
        fetch_pc = {(FW*XLEN){1'b0}};
        for (int i = 0; i < FW; i++) begin
            fetch_pc[i] = pc_r + (XLEN'(unsigned'(i)) << 2'd2);
            chain_v     = chain_v & icache_hit[i];
            live_s[i]   = chain_v;
            chain_v     = chain_v & ~predict_direction[i];
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        logic [XLEN-1:0] target_v;
        logic [XLEN-1:0] count_v;
        logic            taken_v;
        target_v = {XLEN{1'b0}};
        count_v  = {XLEN{1'b0}};
        taken_v  = 1'b0;
        for (int i = 0; i < FW; i++) begin
            target_v = (live_s[i] & predict_direction[i]) ? predict_pc[i] : target_v;
            taken_v  = taken_v | (live_s[i] & predict_direction[i]);
            count_v  = count_v + XLEN'(live_s[i]);
        end

        state_nxt_s = ST_RUN;
        pc_nxt_s    = pc_r;
        if (squash) begin
            state_nxt_s = ST_REDIRECT;
            pc_nxt_s    = {squash_pc[XLEN-1:2], 2'b00};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (stall) begin
                        pc_nxt_s = pc_r;
                    end else if (taken_v) begin
                        pc_nxt_s = {target_v[XLEN-1:2], 2'b00};
                    end else begin
                        pc_nxt_s = pc_r + (count_v << 2'd2);
                    end
                end
                ST_REDIRECT: pc_nxt_s = pc_r;
                default:     pc_nxt_s = pc_r;
            endcase
        end
    end

    // Fetch-group outputs; unused encodings behave as a bubble
    always_comb begin
        run_s          = (state_r == ST_RUN);
        fetch_EN       = run_s ? {FW{1'b1}} : {FW{1'b0}};
        out_valid      = live_s & {FW{run_s & ~stall & ~squash}};
        out_pred_taken = out_valid & predict_direction;
        out_pred_pc    = {(FW*XLEN){1'b0}};
        for (int i = 0; i < FW; i++) begin
            out_pred_pc[i] = predict_direction[i] ? predict_pc[i] : (fetch_pc[i] + INSN_BYTES);
        end
        state_out      = state_r;
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed, table-driven bench for fetch_pc_gen: one table row per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_fetch_pc_gen;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic [31:0]       squash_pc;
    logic              stall;
    logic [2:0]        icache_hit;
    logic [2:0]        predict_direction;
    logic [2:0][31:0]  predict_pc;
    logic [2:0]        fetch_EN;
    logic [2:0][31:0]  fetch_pc;
    logic [2:0]        out_valid;
    logic [2:0]        out_pred_taken;
    logic [2:0][31:0]  out_pred_pc;
    logic [1:0]        state_out;

    int tests  = 0;
    int fails  = 0;

    fetch_pc_gen #(.XLEN(32), .FW(3), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .squash(squash), .squash_pc(squash_pc),
        .stall(stall), .icache_hit(icache_hit), .predict_direction(predict_direction),
        .predict_pc(predict_pc), .fetch_EN(fetch_EN), .fetch_pc(fetch_pc),
        .out_valid(out_valid), .out_pred_taken(out_pred_taken),
        .out_pred_pc(out_pred_pc), .state_out(state_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        sq;
        logic [31:0] sq_pc;
        logic        st;
        logic [2:0]  hit;
        logic [2:0]  dir;
        logic [31:0] pp0;
        logic [31:0] pp1;
        logic [31:0] pp2;
        logic [2:0]  e_en;
        logic [31:0] e_pc0;
        logic [31:0] e_pc2;
        logic [2:0]  e_val;
        logic [2:0]  e_tk;
        logic [1:0]  e_st;
        logic [31:0] e_pp1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sq, input logic [31:0] sq_pc, input logic st,
                       input logic [2:0] hit, input logic [2:0] dir,
                       input logic [31:0] pp0, input logic [31:0] pp1, input logic [31:0] pp2,
                       input logic [2:0] e_en, input logic [31:0] e_pc0, input logic [31:0] e_pc2,
                       input logic [2:0] e_val, input logic [2:0] e_tk, input logic [1:0] e_st,
                       input logic [31:0] e_pp1);
        vec_t v;
        v = '{sq, sq_pc, st, hit, dir, pp0, pp1, pp2, e_en, e_pc0, e_pc2, e_val, e_tk, e_st, e_pp1};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // cycle-by-cycle trace; PC after each row is implied by the next row's fetch_pc[0]
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd0,   32'd8,   3'b111, 3'b000, 2'd0, 32'd8);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd12,  32'd20,  3'b111, 3'b000, 2'd0, 32'd20);
        add(1, 32'd4,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd24,  32'd32,  3'b000, 3'b000, 2'd0, 32'd32);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 32'd4,   32'd12,  3'b000, 3'b000, 2'd1, 32'd12);
        add(0, 32'h0,   0, 3'b111, 3'b010, 0, 32'd80, 0, 3'b111, 32'd4, 32'd12, 3'b011, 3'b010, 2'd0, 32'd80);
        add(1, 32'd16,  0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd80,  32'd88,  3'b000, 3'b000, 2'd0, 32'd88);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 32'd16,  32'd24,  3'b000, 3'b000, 2'd1, 32'd24);
        add(0, 32'h0,   0, 3'b011, 3'b000, 0, 0, 0, 3'b111, 32'd16,  32'd24,  3'b011, 3'b000, 2'd0, 32'd24);
        for (int k = 0; k < 3; k++)
            add(0, 32'h0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 32'd24, 32'd32, 3'b000, 3'b000, 2'd0, 32'd32);
        add(0, 32'h0,   0, 3'b011, 3'b000, 0, 0, 0, 3'b111, 32'd24,  32'd32,  3'b011, 3'b000, 2'd0, 32'd32);
        for (int k = 0; k < 2; k++)
            add(0, 32'h0, 1, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd32, 32'd40, 3'b000, 3'b000, 2'd0, 32'd40);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd32,  32'd40,  3'b111, 3'b000, 2'd0, 32'd40);
        add(1, 32'h103, 1, 3'b111, 3'b001, 32'h500, 0, 0, 3'b111, 32'd44, 32'd52, 3'b000, 3'b000, 2'd0, 32'd52);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 32'h100, 32'h108, 3'b000, 3'b000, 2'd1, 32'h108);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'h100, 32'h108, 3'b111, 3'b000, 2'd0, 32'h108);
        add(1, 32'h40,  0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'h10C, 32'h114, 3'b000, 3'b000, 2'd0, 32'h114);
        add(1, 32'd200, 0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 32'h40,  32'h48,  3'b000, 3'b000, 2'd1, 32'h48);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 32'd200, 32'd208, 3'b000, 3'b000, 2'd1, 32'd208);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'd200, 32'd208, 3'b111, 3'b000, 2'd0, 32'd208);
        add(0, 32'h0,   0, 3'b101, 3'b100, 0, 0, 32'h900, 3'b111, 32'd212, 32'd220, 3'b001, 3'b000, 2'd0, 32'd220);
        add(0, 32'h0,   0, 3'b111, 3'b100, 0, 0, 32'h903, 3'b111, 32'd216, 32'd224, 3'b111, 3'b100, 2'd0, 32'd224);
        add(1, 32'hFFFFFFF8, 0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'h900, 32'h908, 3'b000, 3'b000, 2'd0, 32'h908);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 32'hFFFFFFF8, 32'h0, 3'b000, 3'b000, 2'd1, 32'h0);
        add(0, 32'h0,   0, 3'b111, 3'b000, 0, 0, 0, 3'b111, 32'hFFFFFFF8, 32'h0, 3'b111, 3'b000, 2'd0, 32'h0);
        add(0, 32'h0,   0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 32'd4,   32'd12,  3'b000, 3'b000, 2'd0, 32'd12);

        reset = 1'b1; squash = 1'b0; squash_pc = 32'h0; stall = 1'b0;
        icache_hit = 3'b000; predict_direction = 3'b000; predict_pc = '0;
        @(negedge clock); #1;
        chk("reset_pc",    -1, fetch_pc[0], 32'h0);
        chk("reset_state", -1, {30'd0, state_out}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            squash = vecs[i].sq;  squash_pc = vecs[i].sq_pc;  stall = vecs[i].st;
            icache_hit = vecs[i].hit;  predict_direction = vecs[i].dir;
            predict_pc[0] = vecs[i].pp0; predict_pc[1] = vecs[i].pp1; predict_pc[2] = vecs[i].pp2;
            #1;
            chk("fetch_EN",    i, {29'd0, fetch_EN},       {29'd0, vecs[i].e_en});
            chk("fetch_pc0",   i, fetch_pc[0],             vecs[i].e_pc0);
            chk("fetch_pc2",   i, fetch_pc[2],             vecs[i].e_pc2);
            chk("out_valid",   i, {29'd0, out_valid},      {29'd0, vecs[i].e_val});
            chk("pred_taken",  i, {29'd0, out_pred_taken}, {29'd0, vecs[i].e_tk});
            chk("state",       i, {30'd0, state_out},      {30'd0, vecs[i].e_st});
            chk("out_pred_pc1", i, out_pred_pc[1],         vecs[i].e_pp1);
        end

        // asynchronous reset while a REDIRECT bubble is pending
        @(negedge clock);
        squash = 1'b1; squash_pc = 32'h300; stall = 1'b0;
        icache_hit = 3'b111; predict_direction = 3'b000; predict_pc = '0;
        @(posedge clock); #1;
        squash = 1'b0;
        chk("pre_reset_state", 100, {30'd0, state_out}, 32'd1);
        chk("pre_reset_pc",    100, fetch_pc[0], 32'h300);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_pc",    101, fetch_pc[0], 32'h0);
        chk("async_reset_state", 101, {30'd0, state_out}, 32'd0);
        chk("async_reset_en",    101, {29'd0, fetch_EN}, 32'd7);
        reset = 1'b0;
        @(negedge clock); #1;
        chk("post_reset_valid", 102, {29'd0, out_valid}, 32'd7);
        @(posedge clock); #1;
        chk("post_reset_pc",    103, fetch_pc[0], 32'd12);
        chk("post_reset_state", 103, {30'd0, state_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
